sa_cache_ctrl: RTL and testbench

Controller for the 2-way set-associative, write-back, write-allocate cache. It sits between the CPU load/store port and main memory. It drives the index/write-enable/write-data ports of two data memories and two tag memories (one each per way) and reads their combinational outputs. It also initialises the tag memories after reset and handles hit, refill and dirty-eviction sequencing.

---
 rtl/sa_cache_ctrl_pkg.sv | 46 ++++
 rtl/sa_cache_ctrl_tag_mem.sv | 19 +
 rtl/sa_cache_ctrl.sv | 136 +++++++++++++
 tb/tb_sa_cache_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/sa_cache_ctrl_pkg.sv
// cache_definition: shared types and address-field constants for the 2-way set-associative cache.
package cache_definition;
    localparam int TAG_MSB   = 31;
    localparam int TAG_LSB   = 14;
    localparam int INDEX_LSB = 4;
    localparam int WORD_LSB  = 2;

    typedef struct packed {
        logic [9:0] index;
        logic       we;
    } cache_index_type;

    typedef logic [127:0] cache_data_type;

    typedef struct packed {
        logic                       valid;
        logic                       dirty;
        logic [TAG_MSB-TAG_LSB:0]   tag;
    } cache_tag_type;

    typedef struct packed {
        logic        valid;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } cpu_req_type;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } cpu_result_type;

    typedef struct packed {
        logic           valid;
        logic           rw;
        logic [31:0]    addr;
        cache_data_type data;
    } mem_req_type;

    typedef struct packed {
        logic           ready;
        cache_data_type data;
    } mem_data_type;

    typedef enum logic [2:0] {INIT, IDLE, COMPARE, WRITE_BACK, ALLOCATE} cache_state_type;
endpackage

// File: rtl/sa_cache_ctrl_tag_mem.sv
// sa_cache_tag_mem: one way of tag storage; combinational read, write on the rising edge when we is set.
module sa_cache_tag_mem
    import cache_definition::*;
#(
    parameter int SETS = 1024
)(
    input  logic            clk,
    input  cache_index_type i_idx,
    input  cache_tag_type   i_wr,
    output cache_tag_type   o_rd
);
    cache_tag_type r_mem [SETS];

    always_ff @(posedge clk) begin
        if (i_idx.we) r_mem[i_idx.index] <= i_wr;
    end

    assign o_rd = r_mem[i_idx.index];
endmodule

// File: rtl/sa_cache_ctrl.sv
// sa_cache_ctrl: 2-way set-associative write-back/write-allocate cache controller.
// Defining SA_CACHE_STATS_EN adds hit_count/miss_count outputs.
module sa_cache_ctrl
    import cache_definition::*;
#(
    parameter int SETS           = 1024,
    parameter int INIT_EN_CYCLES = SETS
)(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cpu_req_valid,
    output logic            cpu_req_ready,
    input  logic            cpu_req_rw,
    input  logic [31:0]     cpu_req_addr,
    input  logic [31:0]     cpu_req_data,
    output logic            cpu_res_valid,
    output logic [31:0]     cpu_res_data,
    output logic            mem_req_valid,
    output logic            mem_req_rw,
    output logic [31:0]     mem_req_addr,
    output logic [127:0]    mem_req_data,
    input  logic            mem_res_ready,
    input  logic [127:0]    mem_res_data,
    output cache_index_type data_idx [2],
    output cache_data_type  data_wr  [2],
    input  cache_data_type  data_rd  [2],
    output cache_index_type tag_idx  [2],
    output cache_tag_type   tag_wr   [2],
    input  cache_tag_type   tag_rd   [2]
`ifdef SA_CACHE_STATS_EN
    ,
    output logic [31:0]     hit_count,
    output logic [31:0]     miss_count
`endif
);
    localparam int CW = $clog2(INIT_EN_CYCLES + 1);

    cache_state_type    r_state;
    logic [CW-1:0]      r_cnt;
    logic [SETS-1:0]    r_lru;
    cpu_req_type        r_req;
    logic               r_victim;
    logic               r_refill;

    logic [TAG_MSB-TAG_LSB:0] w_tag;
    logic [9:0]         w_idx;
    logic [1:0]         w_word;
    logic [1:0]         w_hit;
    logic               w_hway;
    logic               w_vict;
    logic               w_cmp;
    logic               w_unused;

    assign w_tag    = r_req.addr[TAG_MSB:TAG_LSB];
    assign w_idx    = r_req.addr[TAG_LSB-1:INDEX_LSB];
    assign w_word   = r_req.addr[INDEX_LSB-1:WORD_LSB];
    assign w_cmp    = r_state == COMPARE;
    assign w_hit[0] = tag_rd[0].valid && tag_rd[0].tag == w_tag;
    assign w_hit[1] = tag_rd[1].valid && tag_rd[1].tag == w_tag;
    assign w_hway   = ~w_hit[0];
    // Fill an empty way first (way 0 wins), otherwise evict the least recently used.
    assign w_vict   = !tag_rd[0].valid ? 1'b0 : !tag_rd[1].valid ? 1'b1 : ~r_lru[w_idx];
    assign w_unused = &{1'b0, r_req.valid, r_req.addr[WORD_LSB-1:0]};

    for (genvar w = 0; w < 2; w++) begin : g_way
        logic           w_we;
        cache_data_type w_blk;
        always_comb begin
            w_blk = data_rd[w];
            w_blk[w_word*32 +: 32] = r_req.data;
        end
        assign w_we = (w_cmp && r_req.rw && (|w_hit) && w_hway == 1'(w)) ||
                      (r_state == ALLOCATE && mem_res_ready && r_victim == 1'(w));
        assign data_idx[w] = '{index: w_idx, we: w_we};
        assign data_wr[w]  = !w_we ? '0 : r_state == ALLOCATE ? mem_res_data : w_blk;
        assign tag_idx[w]  = '{index: r_state == INIT ? 10'(r_cnt) : w_idx, we: w_we || r_state == INIT};
        assign tag_wr[w]   = !w_we ? '0 : '{valid: 1'b1, dirty: r_state != ALLOCATE, tag: w_tag};
    end

    assign cpu_req_ready = r_state == IDLE;
    assign cpu_res_valid = w_cmp && (|w_hit);
    assign cpu_res_data  = cpu_res_valid && !r_req.rw ? data_rd[w_hway][w_word*32 +: 32] : '0;
    assign mem_req_valid = r_state == WRITE_BACK || r_state == ALLOCATE;
    assign mem_req_rw    = r_state == WRITE_BACK;
    assign mem_req_addr  = !mem_req_valid ? '0 : {mem_req_rw ? tag_rd[r_victim].tag : w_tag, w_idx, 4'b0};
    assign mem_req_data  = mem_req_rw ? data_rd[r_victim] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= INIT;
            r_cnt    <= '0;
            r_lru    <= '0;
            r_req    <= '0;
            r_victim <= 1'b0;
            r_refill <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(INIT_EN_CYCLES - 1)) r_state <= IDLE;
                end
                IDLE: if (cpu_req_valid) begin
                    r_req    <= '{valid: 1'b1, rw: cpu_req_rw, addr: cpu_req_addr, data: cpu_req_data};
                    r_refill <= 1'b0;
                    r_state  <= COMPARE;
                end
                COMPARE: if (|w_hit) begin
                    r_lru[w_idx] <= w_hway;
                    r_state      <= IDLE;
                end else begin
                    r_victim <= w_vict;
                    r_state  <= tag_rd[w_vict].dirty ? WRITE_BACK : ALLOCATE;
                end
                WRITE_BACK: if (mem_res_ready) r_state <= ALLOCATE;
                ALLOCATE: if (mem_res_ready) begin
                    r_refill <= 1'b1;
                    r_state  <= COMPARE;
                end
                default: r_state <= INIT;
            endcase
        end
    end

`ifdef SA_CACHE_STATS_EN
    // The COMPARE after a refill always hits and is not a new access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (w_cmp) begin
            if (!(|w_hit)) miss_count <= miss_count + 32'd1;
            else if (!r_refill) hit_count <= hit_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_sa_cache_ctrl.sv
// tb_sa_cache_ctrl: directed test of sa_cache_ctrl with two tag memories and behavioural data memories.
module tb_sa_cache_ctrl;
    import cache_definition::*;

    localparam logic [127:0] BLK_A  = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
    localparam logic [127:0] BLK_AW = 128'h0000DDDD_0000CCCC_12345678_0000AAAA;
    localparam logic [127:0] BLK_B  = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    localparam logic [127:0] BLK_C  = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cpu_req_valid = 1'b0, cpu_req_rw = 1'b0;
    logic [31:0] cpu_req_addr = '0, cpu_req_data = '0;
    logic cpu_req_ready, cpu_res_valid;
    logic [31:0] cpu_res_data;
    logic mem_req_valid, mem_req_rw;
    logic [31:0] mem_req_addr;
    logic [127:0] mem_req_data;
    logic mem_res_ready = 1'b0;
    logic [127:0] mem_res_data = '0;
    cache_index_type data_idx [2];
    cache_index_type tag_idx  [2];
    cache_data_type  data_wr  [2];
    cache_data_type  data_rd  [2];
    cache_tag_type   tag_wr   [2];
    cache_tag_type   tag_rd   [2];
    cache_data_type  dmem [2][1024];
`ifdef SA_CACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif
    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sa_cache_ctrl u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_rw(cpu_req_rw),
        .cpu_req_addr(cpu_req_addr), .cpu_req_data(cpu_req_data),
        .cpu_res_valid(cpu_res_valid), .cpu_res_data(cpu_res_data),
        .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw), .mem_req_addr(mem_req_addr),
        .mem_req_data(mem_req_data), .mem_res_ready(mem_res_ready), .mem_res_data(mem_res_data),
        .data_idx(data_idx), .data_wr(data_wr), .data_rd(data_rd),
        .tag_idx(tag_idx), .tag_wr(tag_wr), .tag_rd(tag_rd)
`ifdef SA_CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    sa_cache_tag_mem u_tag0 (.clk(clk), .i_idx(tag_idx[0]), .i_wr(tag_wr[0]), .o_rd(tag_rd[0]));
    sa_cache_tag_mem u_tag1 (.clk(clk), .i_idx(tag_idx[1]), .i_wr(tag_wr[1]), .o_rd(tag_rd[1]));

    always @(posedge clk) begin
        for (int w = 0; w < 2; w++)
            if (data_idx[w].we) dmem[w][data_idx[w].index] <= data_wr[w];
    end

    always_comb begin
        for (int w = 0; w < 2; w++) data_rd[w] = dmem[w][data_idx[w].index];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_init(input string tag, input int exp_cycles);
        int n = 0;
        while (!cpu_req_ready && n < 2000) begin @(negedge clk); n++; end
        chk(tag, 128'(n), 128'(exp_cycles));
    endtask

    task automatic send(input logic rw, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        while (!cpu_req_ready && n < 50) begin @(negedge clk); n++; end
        chk("req_ready", 128'(cpu_req_ready), 128'(1));
        cpu_req_valid = 1'b1; cpu_req_rw = rw; cpu_req_addr = addr; cpu_req_data = data;
        @(negedge clk);
        cpu_req_valid = 1'b0;
    endtask

    task automatic mem_txn(input string tag, input logic rw, input logic [31:0] addr,
                           input logic [127:0] wdata, input logic [127:0] rdata);
        int n = 0;
        while (!mem_req_valid && n < 10) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, 128'(mem_req_valid), 128'(1));
        chk({tag, "_rw"}, 128'(mem_req_rw), 128'(rw));
        chk({tag, "_addr"}, 128'(mem_req_addr), 128'(addr));
        if (rw) chk({tag, "_data"}, mem_req_data, wdata);
        @(negedge clk);
        chk({tag, "_hold"}, 128'({mem_req_valid, mem_req_rw, mem_req_addr}), 128'({1'b1, rw, addr}));
        mem_res_ready = 1'b1; mem_res_data = rdata;
        @(negedge clk);
        mem_res_ready = 1'b0; mem_res_data = '0;
    endtask

    task automatic expect_res(input string tag, input logic [31:0] data);
        int n = 0;
        while (!cpu_res_valid && n < 5) begin @(negedge clk); n++; end
        chk({tag, "_valid"}, 128'(cpu_res_valid), 128'(1));
        chk({tag, "_data"}, 128'(cpu_res_data), 128'(data));
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nz;
        repeat (2) @(negedge clk);
        chk("rst_ctrl", 128'({cpu_req_ready, cpu_res_valid, mem_req_valid, mem_req_rw, mem_req_addr}), '0);
        chk("rst_data", 128'({mem_req_data, cpu_res_data}), '0);
        chk("rst_data_we", 128'({data_idx[0].we, data_idx[1].we}), '0);
        chk("rst_state", 128'(u_dut.r_state), 128'(INIT));
        rst_n = 1'b1;
        wait_init("init_len", 1024);
        nz = 0;
        for (int i = 0; i < 1024; i++) begin
            if (u_tag0.r_mem[i].valid !== 1'b0) nz++;
            if (u_tag1.r_mem[i].valid !== 1'b0) nz++;
        end
        chk("init_tags_invalid", 128'(nz), '0);

        send(1'b0, 32'h0000_0010, '0);
        chk("miss_nores", 128'(cpu_res_valid), '0);
        mem_txn("fill_a", 1'b0, 32'h0000_0010, '0, BLK_A);
        chk("fill_drop", 128'(mem_req_valid), '0);
        expect_res("rd_a", 32'h0000_AAAA);

        send(1'b0, 32'h0000_0010, '0);
        chk("hit_lat", 128'(cpu_res_valid), 128'(1));
        chk("hit_data", 128'(cpu_res_data), 128'(32'h0000_AAAA));
        chk("hit_nomem", 128'(mem_req_valid), '0);
        @(negedge clk);
        chk("hit_next_ready", 128'(cpu_req_ready), 128'(1));

        send(1'b1, 32'h0000_0014, 32'h1234_5678);
        chk("wr_hit", 128'(cpu_res_valid), 128'(1));
        @(negedge clk);
        chk("wr_tag_dirty", 128'(u_tag0.r_mem[1]), 128'({1'b1, 1'b1, 18'd0}));
        chk("wr_blk", dmem[0][1], BLK_AW);
        send(1'b0, 32'h0000_0014, '0);
        chk("rd_wr_valid", 128'(cpu_res_valid), 128'(1));
        chk("rd_wr_data", 128'(cpu_res_data), 128'(32'h1234_5678));
        @(negedge clk);

        send(1'b0, 32'h0000_4010, '0);
        mem_txn("fill_b", 1'b0, 32'h0000_4010, '0, BLK_B);
        expect_res("rd_b", 32'hB0B0_B0B0);

        send(1'b0, 32'h0000_8010, '0);
        mem_txn("wb_a", 1'b1, 32'h0000_0010, BLK_AW, '0);
        mem_txn("fill_c", 1'b0, 32'h0000_8010, '0, BLK_C);
        expect_res("rd_c", 32'hC0C0_C0C0);
        chk("b_tag_kept", 128'(u_tag1.r_mem[1]), 128'({1'b1, 1'b0, 18'd1}));
        chk("b_blk_kept", dmem[1][1], BLK_B);
        chk("c_tag", 128'(u_tag0.r_mem[1]), 128'({1'b1, 1'b0, 18'd2}));
`ifdef SA_CACHE_STATS_EN
        chk("hit_count", 128'(hit_count), 128'(3));
        chk("miss_count", 128'(miss_count), 128'(3));
`endif

        send(1'b0, 32'h0000_C020, '0);
        begin
            int n = 0;
            while (!mem_req_valid && n < 10) begin @(negedge clk); n++; end
        end
        chk("abort_pre", 128'({mem_req_valid, mem_req_rw}), 128'(2'b10));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_ctrl", 128'({cpu_req_ready, cpu_res_valid, mem_req_valid, mem_req_rw, mem_req_addr}), '0);
        chk("abort_state", 128'(u_dut.r_state), 128'(INIT));
        @(negedge clk);
        rst_n = 1'b1;
        mem_res_ready = 1'b1; mem_res_data = BLK_C;
        @(negedge clk);
        mem_res_ready = 1'b0; mem_res_data = '0;
        chk("late_res_ignored", 128'({u_dut.r_state, data_idx[0].we, data_idx[1].we}), 128'({INIT, 2'b00}));
`ifdef SA_CACHE_STATS_EN
        chk("stats_rst", 128'({hit_count, miss_count}), '0);
`endif
        wait_init("reinit_len", 1023);

        send(1'b0, 32'h0000_0010, '0);
        mem_txn("refill_after_rst", 1'b0, 32'h0000_0010, '0, BLK_A);
        expect_res("rd_after_rst", 32'h0000_AAAA);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
